// File: rtl/btn_ctrl.sv
// btn_ctrl: front-panel button conditioner for the clk27 domain.
// Turns synchronized active-low button bits into debounced levels,
// press / release / long-press pulses and a wrapping 8-bit event counter
// that the CPU polls the same way it polls the IR receiver.
// Optional build macro: BTN_AUTOREPEAT_EN adds auto-repeat pulses on
// btn_long_pulse while a long-pressed button stays held.
module btn_ctrl #(
    parameter int NUM_BTN          = 2,
    parameter int DEBOUNCE_CYCLES  = 270000,
    parameter int LONGPRESS_CYCLES = 27000000,
    parameter int REPEAT_CYCLES    = 5400000
) (
    input  logic               clk27,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_sync_n,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long_pulse,
    output logic [7:0]         btn_event_cnt
);

    localparam int DebW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HoldW = $clog2(LONGPRESS_CYCLES + 1);

    localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE_CYCLES);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONGPRESS_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RepW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } btnState_e;

    // Next-cycle pulse values from every button, gathered so the shared
    // event counter can advance on the same edge the pulses are registered.
    logic [NUM_BTN-1:0] pressNext;
    logic [NUM_BTN-1:0] releaseNext;
    logic [NUM_BTN-1:0] longPulseNext;

    logic       anyEvent;
    logic [7:0] eventCnt_q;
    logic [7:0] eventCnt_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : gBtn

        btnState_e       state_q, state_d;
        logic [DebW-1:0] debCnt_q, debCnt_d;
        logic [HoldW-1:0] holdCnt_q, holdCnt_d;
        logic            long_q, long_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            longPulse_q, longPulse_d;
        logic            raw;
`ifdef BTN_AUTOREPEAT_EN
        logic [RepW-1:0] repCnt_q, repCnt_d;
`endif

        assign raw = ~btn_sync_n[i];

        // Per-button debounce / hold FSM: next state, counters and pulses.
        always_comb begin
            state_d     = state_q;
            debCnt_d    = debCnt_q;
            holdCnt_d   = holdCnt_q;
            long_d      = long_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            longPulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repCnt_d    = repCnt_q;
`endif
            unique case (state_q)
                IDLE: begin
                    if (raw) begin
                        state_d  = DEB_PRESS;
                        debCnt_d = DebW'(1);
                    end
                end
                DEB_PRESS: begin
                    if (!raw) begin
                        state_d = IDLE;
                    end else if (debCnt_q == DebMax) begin
                        state_d   = HELD;
                        level_d   = 1'b1;
                        press_d   = 1'b1;
                        holdCnt_d = '0;
                    end else begin
                        debCnt_d = debCnt_q + DebW'(1);
                    end
                end
                HELD: begin
                    if (!raw) begin
                        state_d  = DEB_RELEASE;
                        debCnt_d = DebW'(1);
                    end else begin
                        if (holdCnt_q != HoldMax) begin
                            holdCnt_d = holdCnt_q + HoldW'(1);
                        end
                        if (!long_q && (holdCnt_d == HoldMax)) begin
                            long_d      = 1'b1;
                            longPulse_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            repCnt_d    = '0;
`endif
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (long_q) begin
                            if (repCnt_q == RepLast) begin
                                repCnt_d    = '0;
                                longPulse_d = 1'b1;
                            end else begin
                                repCnt_d = repCnt_q + RepW'(1);
                            end
                        end
`endif
                    end
                end
                DEB_RELEASE: begin
                    if (raw) begin
                        state_d = HELD;
                    end else if (debCnt_q == DebMax) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        long_d    = 1'b0;
                        release_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        repCnt_d  = '0;
`endif
                    end else begin
                        debCnt_d = debCnt_q + DebW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Per-button state and output registers with synchronous reset.
        always_ff @(posedge clk27) begin
            if (!reset_n) begin
                state_q     <= IDLE;
                debCnt_q    <= '0;
                holdCnt_q   <= '0;
                long_q      <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                longPulse_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                repCnt_q    <= '0;
`endif
            end else begin
                state_q     <= state_d;
                debCnt_q    <= debCnt_d;
                holdCnt_q   <= holdCnt_d;
                long_q      <= long_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                longPulse_q <= longPulse_d;
`ifdef BTN_AUTOREPEAT_EN
                repCnt_q    <= repCnt_d;
`endif
            end
        end

        assign btn_state[i]      = level_q;
        assign btn_long[i]       = long_q;
        assign btn_press[i]      = press_q;
        assign btn_release[i]    = release_q;
        assign btn_long_pulse[i] = longPulse_q;

        assign pressNext[i]     = press_d;
        assign releaseNext[i]   = release_d;
        assign longPulseNext[i] = longPulse_d;
    end

    // Any pulse from any button on this edge counts as a single event.
    always_comb begin
        anyEvent   = |(pressNext | releaseNext | longPulseNext);
        eventCnt_d = eventCnt_q + {7'd0, anyEvent};
    end

    // Event counter register; wraps silently from 255 to 0.
    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            eventCnt_q <= '0;
        end else begin
            eventCnt_q <= eventCnt_d;
        end
    end

    assign btn_event_cnt = eventCnt_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: scoreboard bench for btn_ctrl with short debounce, long-press
// and repeat periods. A behavioural model built on run lengths of raw samples
// predicts every event; a monitor pairs the DUT's pulses with those predictions.
module tb_btn_ctrl;

    localparam int NB   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic          clk27 = 1'b0;
    logic          reset_n;
    logic [NB-1:0] btn_sync_n;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_long;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long_pulse;
    logic [7:0]    btn_event_cnt;

    btn_ctrl #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DEB),
        .LONGPRESS_CYCLES(LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk27(clk27),
        .reset_n(reset_n),
        .btn_sync_n(btn_sync_n),
        .btn_state(btn_state),
        .btn_long(btn_long),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long_pulse(btn_long_pulse),
        .btn_event_cnt(btn_event_cnt)
    );

    // Free-running 100 MHz-style bench clock; period is arbitrary here.
    always #5 clk27 = ~clk27;

    typedef struct {
        int          tag;
        logic [17:0] v;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails  = 0;
    int   edgeNum = 0;

    // Behavioural model state: accepted level, long flag, run of samples
    // disagreeing with the level, count of steadily-held edges since press.
    logic [NB-1:0] mLevel   = '0;
    logic [NB-1:0] mLong    = '0;
    logic [NB-1:0] mPrevRaw = '0;
    logic [NB-1:0] mPress   = '0;
    logic [NB-1:0] mRel     = '0;
    logic [NB-1:0] mLp      = '0;
    logic [7:0]    mCnt     = '0;
    int            mRun[NB];
    int            mHeld[NB];

    task automatic modelStep(input logic rstN, input logic [NB-1:0] raw, input int tag);
        exp_t e;
        mPress = '0;
        mRel   = '0;
        mLp    = '0;
        if (!rstN) begin
            mLevel   = '0;
            mLong    = '0;
            mPrevRaw = '0;
            mCnt     = '0;
            for (int i = 0; i < NB; i++) begin
                mRun[i]  = 0;
                mHeld[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (raw[i] != mLevel[i]) mRun[i] = mRun[i] + 1;
                else                     mRun[i] = 0;
                if (mRun[i] == DEB + 1) begin
                    mRun[i] = 0;
                    if (raw[i]) begin
                        mLevel[i] = 1'b1;
                        mPress[i] = 1'b1;
                        mHeld[i]  = 0;
                    end else begin
                        mLevel[i] = 1'b0;
                        mLong[i]  = 1'b0;
                        mRel[i]   = 1'b1;
                    end
                end else if (mLevel[i] && raw[i] && mPrevRaw[i]) begin
                    mHeld[i] = mHeld[i] + 1;
                    if (mHeld[i] == LONG) begin
                        mLong[i] = 1'b1;
                        mLp[i]   = 1'b1;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (mHeld[i] > LONG && ((mHeld[i] - LONG) % REP) == 0) begin
                        mLp[i] = 1'b1;
                    end
`endif
                end
                mPrevRaw[i] = raw[i];
            end
            if (|{mPress, mRel, mLp}) begin
                mCnt  = mCnt + 8'd1;
                e.tag = tag;
                e.v   = {mPress, mRel, mLp, mLevel, mLong, mCnt};
                expQ.push_back(e);
            end
        end
    endtask

    // One clock of stimulus: drive at the falling edge, model the next rising edge.
    task automatic driveCycle(input logic rstN, input logic [NB-1:0] btnN);
        @(negedge clk27);
        reset_n    = rstN;
        btn_sync_n = btnN;
        modelStep(rstN, ~btnN, edgeNum + 1);
    endtask

    task automatic applyStimulus(input logic [NB-1:0] btnN, input int cycles);
        for (int k = 0; k < cycles; k++) driveCycle(1'b1, btnN);
    endtask

    task automatic doReset(input int cycles);
        for (int k = 0; k < cycles; k++) driveCycle(1'b0, btn_sync_n);
    endtask

    // Compare the whole output bundle after the edge just modelled.
    task automatic checkOutput(input string name);
        logic [17:0] expV;
        logic [17:0] actV;
        @(posedge clk27);
        #1;
        expV = {mPress, mRel, mLp, mLevel, mLong, mCnt};
        actV = {btn_press, btn_release, btn_long_pulse, btn_state, btn_long, btn_event_cnt};
        checks++;
        if (actV !== expV) begin
            fails++;
            $display("[TB] FAIL %s: got %h want %h (press,release,longPulse,state,long,cnt)",
                     name, actV, expV);
        end
    endtask

    // Monitor: whenever the DUT shows a pulse, pop the predicted event and compare.
    exp_t        monE;
    logic [17:0] monAct;
    initial begin
        forever begin
            @(posedge clk27);
            edgeNum++;
            #1;
            while (expQ.size() > 0 && expQ[0].tag < edgeNum) begin
                monE = expQ.pop_front();
                checks++;
                fails++;
                $display("[TB] FAIL missingEvent: edge %0d got no pulse, want %h", monE.tag, monE.v);
            end
            monAct = {btn_press, btn_release, btn_long_pulse, btn_state, btn_long, btn_event_cnt};
            if (|{btn_press, btn_release, btn_long_pulse}) begin
                checks++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpectedEvent: edge %0d got %h, want no event", edgeNum, monAct);
                end else begin
                    monE = expQ.pop_front();
                    if (monE.tag != edgeNum || monE.v !== monAct) begin
                        fails++;
                        $display("[TB] FAIL event: edge %0d got %h, want %h at edge %0d",
                                 edgeNum, monAct, monE.v, monE.tag);
                    end
                end
            end
        end
    end

    initial begin
        logic [NB-1:0] rndBtn;
        for (int i = 0; i < NB; i++) begin
            mRun[i]  = 0;
            mHeld[i] = 0;
        end
        reset_n    = 1'b0;
        btn_sync_n = '1;

        doReset(2);
        checkOutput("resetState");

        // Clean press of button 0, then release.
        applyStimulus(2'b10, 10);
        checkOutput("pressLevel");
        applyStimulus(2'b11, 6);
        checkOutput("releaseLevel");

        // Bounce during press debounce.
        applyStimulus(2'b10, 3);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b10, 5);
        checkOutput("bouncePress");
        applyStimulus(2'b11, 6);

        // Long press on button 1, then release.
        applyStimulus(2'b01, 40);
        checkOutput("longHeld");
        applyStimulus(2'b11, 5);
        checkOutput("longRelease");
        applyStimulus(2'b11, 2);

        // Both buttons together.
        applyStimulus(2'b00, 6);
        checkOutput("bothPressed");
        applyStimulus(2'b11, 6);

        // Release bounce while held: long-press timer must not restart.
        applyStimulus(2'b10, 15);
        applyStimulus(2'b11, 2);
        applyStimulus(2'b10, 12);
        checkOutput("holdResume");
        applyStimulus(2'b11, 6);

        // Reset while a button is held.
        applyStimulus(2'b10, 10);
        doReset(1);
        checkOutput("resetMidPress");
        applyStimulus(2'b10, 5);
        checkOutput("repress");
        applyStimulus(2'b11, 6);

        // Counter wrap from 255 to 0.
        doReset(1);
        checkOutput("resetBeforeWrap");
        for (int n = 0; n < 127; n++) begin
            applyStimulus(2'b10, 5);
            applyStimulus(2'b11, 5);
        end
        applyStimulus(2'b10, 5);
        checkOutput("cnt255");
        applyStimulus(2'b11, 5);
        checkOutput("cntWrap");

        // Random segments with bounces, long holds and rare resets.
        for (int n = 0; n < 250; n++) begin
            rndBtn = NB'($urandom);
            if ($urandom_range(0, 39) == 0) doReset(1);
            applyStimulus(rndBtn, int'($urandom_range(1, 28)));
            checkOutput("random");
        end

        applyStimulus(2'b11, 10);
        @(posedge clk27);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL leftoverEvents: got %0d pending, want 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
